// File: rtl/clock_pkg.sv
// Shared constants, FSM state type and BCD helper for the digital clock
// beep control path.
package clock_pkg;

  localparam logic [7:0] CHIME_MIN       = 8'h59;
  localparam logic [7:0] CHIME_SEC_FIRST = 8'h55;
  localparam logic [7:0] CHIME_SEC_LAST  = 8'h59;
  localparam logic [7:0] TOP_MIN         = 8'h00;
  localparam logic [7:0] TOP_SEC         = 8'h00;

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

endpackage

// File: rtl/chime_alarm_ctrl_if.sv
// Bundle between the time/alarm registers, the beep controller and the
// buzzer driver.
interface chime_alarm_ctrl_if;
  import clock_pkg::*;

  // beepen is a level request with no ready/ack: the buzzer sounds while it
  // is high, and the controller alone owns pulse width and spacing.
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [7:0] alarm_hour_bcd;
  logic [7:0] alarm_min_bcd;
  logic       alarm_on;
  logic       chime_on;
  logic       stop_key;
  logic       beepen;
  logic       alarm_active;
  state_t     state_dbg;

  modport master (
    input  hour_bcd, min_bcd, sec_bcd, alarm_hour_bcd, alarm_min_bcd,
    input  alarm_on, chime_on, stop_key,
    output beepen, alarm_active, state_dbg
  );

  modport slave (
    output hour_bcd, min_bcd, sec_bcd, alarm_hour_bcd, alarm_min_bcd,
    output alarm_on, chime_on, stop_key,
    input  beepen, alarm_active, state_dbg
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser and registered rising-edge detect for the 1 Hz
// level, with a short post-reset blanking window.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tick
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic       tick_q, tick_d;
  logic [1:0] sup_cnt_q, sup_cnt_d;

  // The chain restarts from 0 after reset, so a level already high would
  // look like an edge; blank detection until the chain has refilled.
  always_comb begin
    sync1_d   = din;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    sup_cnt_d = (sup_cnt_q == 2'd3) ? sup_cnt_q : sup_cnt_q + 2'd1;
    tick_d    = sync2_q && !prev_q && (sup_cnt_q == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      tick_q    <= 1'b0;
      sup_cnt_q <= 2'd0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      tick_q    <= tick_d;
      sup_cnt_q <= sup_cnt_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/chime_alarm_ctrl.sv
// Decides when the clock beeps (hourly chime, repeating alarm) and shapes
// each beep into a fixed-width beepen pulse.
module chime_alarm_ctrl
  import clock_pkg::*;
#(
  parameter int PULSE_CYC  = 50,
  parameter int ALARM_SECS = 60
) (
  input  logic                clk50mhz,
  input  logic                rst,
  input  logic                clk1hz,
  chime_alarm_ctrl_if.master  bus
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYC);
  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS - 1);

  logic       sec_tick;
  state_t     state_q, state_d;
  logic [7:0] secs_q, secs_d;
  logic [7:0] pulse_q, pulse_d;
  logic       alarm_match;
  logic       chime_hit;
  logic       beep_req;

  sync_edge u_sync_edge (
    .clk  (clk50mhz),
    .rst  (rst),
    .din  (clk1hz),
    .tick (sec_tick)
  );

  assign alarm_match = bus.alarm_on &&
                       is_bcd(bus.hour_bcd) && is_bcd(bus.alarm_hour_bcd) &&
                       is_bcd(bus.min_bcd)  && is_bcd(bus.alarm_min_bcd) &&
                       is_bcd(bus.sec_bcd) &&
                       (bus.hour_bcd == bus.alarm_hour_bcd) &&
                       (bus.min_bcd  == bus.alarm_min_bcd) &&
                       (bus.sec_bcd  == TOP_SEC);

  assign chime_hit = bus.chime_on && is_bcd(bus.min_bcd) && is_bcd(bus.sec_bcd) &&
                     (((bus.min_bcd == CHIME_MIN) &&
                       (bus.sec_bcd >= CHIME_SEC_FIRST) &&
                       (bus.sec_bcd <= CHIME_SEC_LAST)) ||
                      ((bus.min_bcd == TOP_MIN) && (bus.sec_bcd == TOP_SEC)));

  // Dismissal is checked every cycle and ahead of the tick, so a stop that
  // lands on a tick silences that second's beep.
  always_comb begin
    state_d  = state_q;
    secs_d   = secs_q;
    beep_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (sec_tick) begin
          if (alarm_match) begin
            state_d  = ALARM;
            secs_d   = ALARM_LOAD;
            beep_req = 1'b1;
          end else if (chime_hit) begin
            beep_req = 1'b1;
          end
        end
      end
      ALARM: begin
        if (bus.stop_key || !bus.alarm_on) begin
          state_d = IDLE;
        end else if (sec_tick) begin
          if (secs_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            beep_req = 1'b1;
            secs_d   = secs_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A request during a running pulse is dropped rather than extending it.
  always_comb begin
    pulse_d = pulse_q;
    if (pulse_q != 8'd0) begin
      pulse_d = pulse_q - 8'd1;
    end else if (beep_req) begin
      pulse_d = PULSE_LOAD;
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state_q <= IDLE;
      secs_q  <= 8'd0;
      pulse_q <= 8'd0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.beepen       = (pulse_q != 8'd0);
  assign bus.alarm_active = (state_q == ALARM);
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_chime_alarm_ctrl.sv
// Directed and randomized seconds of 1 Hz activity for chime_alarm_ctrl,
// checked cycle by cycle against a reference model of the beep rules.
module tb_chime_alarm_ctrl;
  import clock_pkg::*;

  localparam int PULSE   = 50;
  localparam int SECS    = 6;
  localparam int SEC_LEN = 200;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic clk1hz = 1'b0;

  chime_alarm_ctrl_if bus();

  chime_alarm_ctrl #(
    .PULSE_CYC  (PULSE),
    .ALARM_SECS (SECS)
  ) dut (
    .clk50mhz (clk),
    .rst      (rst),
    .clk1hz   (clk1hz),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference model: pending tick time, pulse end time, alarm state.
  int   cyc        = 0;
  int   tick_at    = -1;
  int   pulse_end  = 0;
  int   m_left     = 0;
  bit   m_alarm    = 1'b0;
  int   n_vec      = 0;
  int   n_miss     = 0;
  int   rises      = 0;
  int   run        = 0;
  int   last_width = 0;
  logic prev_beep  = 1'b0;

  function automatic int bcd_val(input logic [7:0] v);
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycle();
    bit due;
    bit beep;
    int h, m, s, ah, am;
    bit amatch, chime;
    @(negedge clk);
    cyc++;
    beep = 1'b0;
    if (rst) begin
      m_alarm   = 1'b0;
      tick_at   = -1;
      pulse_end = cyc;
    end else begin
      due = (tick_at >= 0) && (cyc == tick_at + 4);
      if (due) tick_at = -1;
      if (m_alarm && (bus.stop_key || !bus.alarm_on)) begin
        m_alarm = 1'b0;
      end else if (due) begin
        if (m_alarm) begin
          if (m_left == 0) m_alarm = 1'b0;
          else begin
            beep = 1'b1;
            m_left--;
          end
        end else begin
          h  = bcd_val(bus.hour_bcd);
          m  = bcd_val(bus.min_bcd);
          s  = bcd_val(bus.sec_bcd);
          ah = bcd_val(bus.alarm_hour_bcd);
          am = bcd_val(bus.alarm_min_bcd);
          amatch = bus.alarm_on && h >= 0 && ah >= 0 && m >= 0 && am >= 0 &&
                   s >= 0 && h == ah && m == am && s == 0;
          chime  = bus.chime_on && ((m == 59 && s >= 55 && s <= 59) || (m == 0 && s == 0));
          if (amatch) begin
            m_alarm = 1'b1;
            m_left  = SECS - 1;
            beep    = 1'b1;
          end else begin
            beep = chime;
          end
        end
      end
      if (beep && cyc >= pulse_end) pulse_end = cyc + PULSE;
    end
    chk("beepen", int'(bus.beepen), int'(cyc < pulse_end));
    chk("alarm_active", int'(bus.alarm_active), int'(m_alarm));
    chk("state_dbg", int'(bus.state_dbg == ALARM), int'(m_alarm));
    if (bus.beepen === 1'b1 && prev_beep !== 1'b1) rises++;
    if (bus.beepen === 1'b1) run++;
    else if (run != 0) begin
      last_width = run;
      run = 0;
    end
    prev_beep = bus.beepen;
  endtask

  // One 1 Hz period: rising edge with new time fields, optional stop or
  // reset pulse landing on relative cycle stop_at / rst_at.
  task automatic second(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        input int len, input int stop_at, input int rst_at);
    bus.hour_bcd = h;
    bus.min_bcd  = m;
    bus.sec_bcd  = s;
    clk1hz       = 1'b1;
    tick_at      = cyc;
    for (int k = 1; k <= len; k++) begin
      if (k == len / 2 + 1) clk1hz = 1'b0;
      if (k == stop_at) bus.stop_key = 1'b1;
      if (k == rst_at) rst = 1'b1;
      cycle();
      bus.stop_key = 1'b0;
      rst = 1'b0;
    end
  endtask

  task automatic sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    second(h, m, s, SEC_LEN, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int len, stop_at;
    logic [7:0] h, m, s;

    bus.hour_bcd       = 8'h12;
    bus.min_bcd        = 8'h59;
    bus.sec_bcd        = 8'h55;
    bus.alarm_hour_bcd = 8'h07;
    bus.alarm_min_bcd  = 8'h30;
    bus.alarm_on       = 1'b0;
    bus.chime_on       = 1'b1;
    bus.stop_key       = 1'b0;

    // Reset with clk1hz high: no false tick after release.
    rst    = 1'b1;
    clk1hz = 1'b1;
    repeat (4) cycle();
    chk("reset_beepen", int'(bus.beepen), 0);
    chk("reset_alarm_active", int'(bus.alarm_active), 0);
    rst = 1'b0;
    repeat (SEC_LEN / 2) cycle();
    clk1hz = 1'b0;
    repeat (SEC_LEN / 2) cycle();
    chk("no_false_tick", rises, 0);
    sec(8'h12, 8'h59, 8'h56);
    chk("genuine_tick_after_reset", rises, 1);

    // Hourly chime window 12:59:54 .. 13:00:01.
    r0 = rises;
    for (int i = 54; i <= 59; i++) sec(8'h12, 8'h59, to_bcd(i));
    sec(8'h13, 8'h00, 8'h00);
    sec(8'h13, 8'h00, 8'h01);
    chk("chime_pulse_count", rises - r0, 6);
    chk("chime_pulse_width", last_width, PULSE);

    // Alarm 07:30, stop on entry tick ignored, stop after the :05 beep.
    bus.chime_on = 1'b0;
    bus.alarm_on = 1'b1;
    r0 = rises;
    sec(8'h07, 8'h29, 8'h59);
    second(8'h07, 8'h30, 8'h00, SEC_LEN, 4, 0);
    chk("alarm_entry_active", int'(bus.alarm_active), 1);
    for (int i = 1; i <= 4; i++) sec(8'h07, 8'h30, to_bcd(i));
    second(8'h07, 8'h30, 8'h05, SEC_LEN, 150, 0);
    chk("alarm_after_stop", int'(bus.alarm_active), 0);
    sec(8'h07, 8'h30, 8'h06);
    chk("alarm_stop_pulse_count", rises - r0, 6);

    // Timeout with no stop.
    bus.alarm_hour_bcd = 8'h09;
    bus.alarm_min_bcd  = 8'h15;
    r0 = rises;
    for (int i = 0; i <= SECS; i++) begin
      sec(8'h09, 8'h15, to_bcd(i));
      if (i == SECS - 1) chk("timeout_still_active", int'(bus.alarm_active), 1);
    end
    chk("timeout_pulse_count", rises - r0, SECS);
    chk("timeout_inactive", int'(bus.alarm_active), 0);

    // Alarm on the hour with chime on: one beep; stop on a tick wins.
    bus.chime_on       = 1'b1;
    bus.alarm_hour_bcd = 8'h08;
    bus.alarm_min_bcd  = 8'h00;
    r0 = rises;
    sec(8'h08, 8'h00, 8'h00);
    chk("coincident_single_pulse", rises - r0, 1);
    chk("coincident_active", int'(bus.alarm_active), 1);
    second(8'h08, 8'h00, 8'h01, SEC_LEN, 4, 0);
    chk("stop_beats_tick", rises - r0, 1);
    chk("stop_tick_inactive", int'(bus.alarm_active), 0);

    // Alarm timeout tick falls on a chime second: chime still suppressed.
    bus.alarm_min_bcd = 8'h59;
    r0 = rises;
    sec(8'h08, 8'h59, 8'h00);
    for (int i = 1; i <= SECS - 1; i++) sec(8'h08, 8'h59, to_bcd(i));
    sec(8'h08, 8'h59, 8'h55);
    chk("chime_suppressed_on_exit", rises - r0, SECS);
    chk("exit_inactive", int'(bus.alarm_active), 0);
    sec(8'h08, 8'h59, 8'h56);
    chk("chime_after_exit", rises - r0, SECS + 1);

    // Non-BCD fields never match.
    bus.chime_on       = 1'b0;
    bus.alarm_hour_bcd = 8'h1B;
    bus.alarm_min_bcd  = 8'h00;
    r0 = rises;
    sec(8'h1B, 8'h00, 8'h00);
    bus.alarm_hour_bcd = 8'h10;
    bus.alarm_min_bcd  = 8'h3A;
    sec(8'h10, 8'h3A, 8'h00);
    bus.chime_on = 1'b1;
    sec(8'h10, 8'h59, 8'h5A);
    sec(8'h10, 8'h59, 8'h60);
    chk("non_bcd_no_beep", rises - r0, 0);

    // Reset mid-pulse, then mid-alarm.
    bus.alarm_on = 1'b0;
    second(8'h10, 8'h59, 8'h55, SEC_LEN, 0, 24);
    chk("mid_pulse_reset_width", last_width, 20);
    bus.chime_on       = 1'b0;
    bus.alarm_on       = 1'b1;
    bus.alarm_hour_bcd = 8'h11;
    bus.alarm_min_bcd  = 8'h00;
    r0 = rises;
    sec(8'h11, 8'h00, 8'h00);
    second(8'h11, 8'h00, 8'h01, SEC_LEN, 0, 60);
    chk("alarm_after_reset", int'(bus.alarm_active), 0);
    sec(8'h11, 8'h00, 8'h02);
    chk("reset_alarm_pulse_count", rises - r0, 2);

    // A tick during a running pulse does not stretch it.
    bus.alarm_on = 1'b0;
    bus.chime_on = 1'b1;
    r0 = rises;
    second(8'h12, 8'h59, 8'h55, 20, 0, 0);
    sec(8'h12, 8'h59, 8'h56);
    chk("overlap_single_pulse", rises - r0, 1);
    chk("overlap_pulse_width", last_width, PULSE);

    // Randomized seconds.
    for (int i = 0; i < 40; i++) begin
      bus.chime_on = 1'($urandom_range(0, 1));
      bus.alarm_on = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : to_bcd($urandom_range(0, 23));
      case ($urandom_range(0, 3))
        0:       m = 8'h00;
        1:       m = 8'h59;
        2:       m = to_bcd($urandom_range(0, 59));
        default: m = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 3))
        0:       s = 8'h00;
        1:       s = to_bcd($urandom_range(55, 59));
        2:       s = to_bcd($urandom_range(0, 59));
        default: s = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        bus.alarm_hour_bcd = h;
        bus.alarm_min_bcd  = m;
      end else begin
        bus.alarm_hour_bcd = to_bcd($urandom_range(0, 23));
        bus.alarm_min_bcd  = to_bcd($urandom_range(0, 59));
      end
      len     = $urandom_range(20, SEC_LEN);
      stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len) : 0;
      second(h, m, s, len, stop_at, 0);
    end
    repeat (PULSE + 4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/chime_alarm_ctrl.md
# chime_alarm_ctrl

- Producer side of the buzzer enable interface: decides when the digital clock should beep and issues `beepen` request pulses to the buzzer driver.
- Sources of a beep:
  - hourly chime at the top of each hour;
  - alarm match on hour and minute, which repeats every second until dismissed or timed out.
- Sits between the BCD time/alarm registers and the buzzer block, entirely in the `clk50mhz` domain.
- Samples the slow `clk1hz` level internally.

## Interface
Parameters
- `PULSE_CYC`, 50: width of each `beepen` pulse in `clk50mhz` cycles (1..255).
- `ALARM_SECS`, 60: maximum alarm duration in seconds (1..255).

Ports
- `clk50mhz` in 1: system clock, 50 MHz. One clock only.
- `rst` in 1: synchronous, active-high reset.
- `clk1hz` in 1: 1 Hz square wave, treated as data. Synchronised and edge-detected internally.
- `hour_bcd` in 8: current hour, BCD, 00–23.
- `min_bcd` in 8: current minute, BCD.
- `sec_bcd` in 8: current second, BCD.
- `alarm_hour_bcd` in 8: alarm hour, BCD.
- `alarm_min_bcd` in 8: alarm minute, BCD.
- `alarm_on` in 1: alarm armed (level).
- `chime_on` in 1: hourly chime enabled (level).
- `stop_key` in 1: one-cycle debounced dismiss pulse.
- `beepen` out 1: beep request. High for exactly `PULSE_CYC` cycles per beep.
- `alarm_active` out 1: high while in ALARM state.

## Operation
Second tick
- `clk1hz` passes through a 2-FF synchroniser, then a rising-edge detect produces `sec_tick`, a one-cycle pulse.
- Sync and edge registers reset to 0.
- Edge detection is suppressed for the first 3 cycles after `rst` deasserts, so no false tick is produced when `clk1hz` is high at reset.

Evaluation
- Time inputs are sampled only on cycles where `sec_tick` = 1.
- Any field holding a non-BCD nibble (>9) never matches.

State machine: IDLE, ALARM.
- IDLE → ALARM on `sec_tick` when all hold: `alarm_on`, `hour_bcd` == `alarm_hour_bcd`, `min_bcd` == `alarm_min_bcd`, `sec_bcd` == 8'h00.
  - Issue a beep.
  - Load the second counter with `ALARM_SECS` − 1.
- In IDLE, on `sec_tick`, chime when `chime_on` and either:
  - `min_bcd` == 8'h59 and `sec_bcd` ∈ {55..59}, or
  - `min_bcd` == 8'h00 and `sec_bcd` == 8'h00.
- ALARM → IDLE, no beep, on any of:
  - `stop_key`;
  - `alarm_on` = 0;
  - `sec_tick` with the counter at 0.
- Otherwise, in ALARM, each `sec_tick` beeps and decrements the counter.
- The chime is suppressed while in ALARM.

Priority and coincident events
- Alarm entry and chime in the same second produce one beep, and the block enters ALARM.
- `stop_key` coincident with a `sec_tick` while in ALARM: stop wins, no beep.
- `stop_key` in IDLE is ignored. A `stop_key` on the entry tick is also ignored, because it is evaluated against the current state, IDLE.

Pulse generator
- An 8-bit down-counter is loaded with `PULSE_CYC` on a beep request.
- `beepen` = (counter ≠ 0).
- A request while the counter is nonzero is ignored; the pulse is not extended or restarted.

## Timing
- Reset values: `beepen` = 0, `alarm_active` = 0, state IDLE, all counters 0.
- `sec_tick` is asserted 3 cycles after the `clk1hz` rising edge: 2 sync stages plus 1 edge register.
- `beepen` rises on the cycle after `sec_tick` (registered output) and stays high `PULSE_CYC` cycles.
- `alarm_active` rises in the same cycle as the first alarm `beepen`. It falls the cycle after the terminating event.
- `rst` mid-pulse or mid-alarm: outputs go to 0 on the next edge and the block is in IDLE.
- The time inputs must be stable for at least 2 cycles after `sec_tick`. This is met because the time counter updates on the same `clk1hz` edge, which is earlier.
- Counter wrap: the alarm second counter never wraps. Reaching 0 terminates the alarm.

## Structure
- Shared package `clock_pkg`:
  - BCD constants `CHIME_MIN` = 8'h59, `CHIME_SEC_FIRST` = 8'h55, `TOP_MIN` = 8'h00;
  - the state enum `{IDLE, ALARM}`;
  - an `is_bcd` function.
- One sub-module, `sync_edge`: 2-FF synchroniser, rising-edge detect and post-reset suppression, producing `sec_tick`.
- Everything else is in the top.

## Test plan
- Reset with `clk1hz` held high, then release → no `beepen` for 2 s of simulated ticks except genuine rising edges.
- `chime_on` = 1, step 12:59:54 → 13:00:01 → exactly 6 pulses, each 50 cycles wide:
  - at 59:55–59:59 and 00:00;
  - the first rising 4 cycles after the `clk1hz` edge.
- `alarm_on` = 1, alarm 07:30, time reaches 07:30:00 → `alarm_active` = 1.
  - A pulse occurs every tick.
  - `stop_key` at 07:30:05 → exactly 6 pulses total, `alarm_active` = 0 the next cycle.
- `ALARM_SECS` = 3, no stop → 3 pulses, then `alarm_active` drops on the 3rd following tick.
- Alarm at 08:00 with `chime_on` = 1 → a single pulse at 08:00:00, not two, and chime suppressed afterwards.
- Assert `rst` mid-pulse, 20 cycles in → `beepen` = 0 the next cycle. Assert `sec_tick` during an active pulse → pulse length unchanged.
